// File: rtl/natural_log_pkg.sv
// Shared constants, ln(1+i/64) table and pipeline stage records for natural_log.
// Optional interpolation build: NATURALLOG_INTERP_EN.
package natural_log_pkg;

    localparam int unsigned Q_FRAC    = 16;
    localparam int unsigned LUT_BITS  = 6;
    localparam int unsigned LUT_SIZE  = (1 << LUT_BITS) + 1;
    localparam int unsigned LATENCY   = 3;
    localparam int unsigned REM_BITS  = Q_FRAC - LUT_BITS;
    localparam logic [15:0] LN2_Q16   = 16'd45426;
    localparam logic [31:0] ERR_VALUE = 32'h8000_0000;

    // round(ln(1 + i/64) * 65536), i = 0..64
    localparam logic [16:0] LN_LUT [LUT_SIZE] = '{
        17'd0,     17'd1016,  17'd2017,  17'd3002,  17'd3973,  17'd4930,  17'd5873,  17'd6802,
        17'd7719,  17'd8623,  17'd9515,  17'd10394, 17'd11262, 17'd12119, 17'd12965, 17'd13800,
        17'd14624, 17'd15438, 17'd16242, 17'd17037, 17'd17821, 17'd18597, 17'd19364, 17'd20121,
        17'd20870, 17'd21611, 17'd22343, 17'd23067, 17'd23783, 17'd24492, 17'd25193, 17'd25886,
        17'd26573, 17'd27252, 17'd27924, 17'd28589, 17'd29248, 17'd29900, 17'd30546, 17'd31185,
        17'd31818, 17'd32445, 17'd33067, 17'd33682, 17'd34292, 17'd34896, 17'd35494, 17'd36087,
        17'd36675, 17'd37258, 17'd37835, 17'd38407, 17'd38975, 17'd39537, 17'd40095, 17'd40648,
        17'd41196, 17'd41740, 17'd42280, 17'd42815, 17'd43345, 17'd43872, 17'd44394, 17'd44912,
        17'd45426
    };

    typedef struct packed {
        logic                valid;
        logic                err;
        logic [4:0]          k;
        logic [LUT_BITS-1:0] idx;
`ifdef NATURALLOG_INTERP_EN
        logic [REM_BITS-1:0] rem;
`endif
    } stage1_t;

    typedef struct packed {
        logic                valid;
        logic                err;
        logic [4:0]          k;
        logic [16:0]         lut_lo;
`ifdef NATURALLOG_INTERP_EN
        logic [16:0]         lut_hi;
        logic [REM_BITS-1:0] rem;
`endif
    } stage2_t;

endpackage

// File: rtl/natural_log_if.sv
// Sample stream into and out of natural_log; master drives x, slave returns y/err.
interface natural_log_if;

    logic        in_valid;
    logic [31:0] x;
    logic        out_valid;
    logic [31:0] y;
    logic        err;

    modport master (
        output in_valid,
        output x,
        input  out_valid,
        input  y,
        input  err
    );

    modport slave (
        input  in_valid,
        input  x,
        output out_valid,
        output y,
        output err
    );

endinterface

// File: rtl/natural_log_lod32.sv
// Combinational 32-bit leading-one detector: position of the highest set bit plus an all-zero flag.
module lod32 (
    input  logic [31:0] value,
    output logic [4:0]  pos,
    output logic        zero
);

    always_comb begin
        pos  = '0;
        zero = (value == '0);
        for (int unsigned i = 0; i < 32; i++) begin
            if (value[i]) begin
                pos = i[4:0];
            end
        end
    end

endmodule

// File: rtl/natural_log.sv
// Three-stage pipelined ln(x), x signed 32-bit integer, y signed Q16.16.
// Define NATURALLOG_INTERP_EN for linear interpolation between table entries.
module natural_log
    import natural_log_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET_N,
    natural_log_if.slave bus
);

    logic        v0;
    logic [31:0] x_q;
    logic [4:0]  lod_pos;
    logic        lod_zero;
    stage1_t     s1, s1_next;
    stage2_t     s2, s2_next;
    logic [16:0] lnm;
    logic [31:0] y_next;

    lod32 u_lod (
        .value (x_q),
        .pos   (lod_pos),
        .zero  (lod_zero)
    );

    // Shifting the leading one up to bit 31 left-aligns the mantissa fraction in bits 30:15.
    always_comb begin
        s1_next       = '0;
        s1_next.valid = v0;
        s1_next.err   = x_q[31] | lod_zero;
        s1_next.k     = lod_pos;
        s1_next.idx   = LUT_BITS'((x_q << (5'd31 - lod_pos)) >> (31 - LUT_BITS));
`ifdef NATURALLOG_INTERP_EN
        s1_next.rem   = REM_BITS'((x_q << (5'd31 - lod_pos)) >> 15);
`endif
    end

    always_comb begin
        s2_next        = '0;
        s2_next.valid  = s1.valid;
        s2_next.err    = s1.err;
        s2_next.k      = s1.k;
        s2_next.lut_lo = LN_LUT[s1.idx];
`ifdef NATURALLOG_INTERP_EN
        s2_next.lut_hi = LN_LUT[{1'b0, s1.idx} + 7'd1];
        s2_next.rem    = s1.rem;
`endif
    end

`ifdef NATURALLOG_INTERP_EN
    logic [16:0] slope;
    logic [26:0] prod;

    always_comb begin
        slope = s2.lut_hi - s2.lut_lo;
        prod  = 27'(slope) * 27'(s2.rem);
        lnm   = s2.lut_lo + prod[26:REM_BITS];
    end
`else
    always_comb begin
        lnm = s2.lut_lo;
    end
`endif

    always_comb begin
        y_next = (32'(s2.k) * 32'(LN2_Q16)) + 32'(lnm);
        if (s2.err) begin
            y_next = ERR_VALUE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            v0            <= 1'b0;
            x_q           <= '0;
            s1            <= '0;
            s2            <= '0;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.err       <= 1'b0;
        end else begin
            v0            <= bus.in_valid;
            x_q           <= bus.x;
            s1            <= s1_next;
            s2            <= s2_next;
            bus.out_valid <= s2.valid;
            if (s2.valid) begin
                bus.y   <= y_next;
                bus.err <= s2.err;
            end
        end
    end

endmodule

// File: tb/tb_natural_log.sv
// Self-checking bench for natural_log against a real-valued ln() reference with per-build tolerance.
module tb_natural_log;

    logic clk = 1'b0;
    logic rst_n;

    natural_log_if bus ();

    natural_log dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef NATURALLOG_INTERP_EN
    localparam longint TOL = 4;
`else
    localparam longint TOL = 1030;
`endif
    localparam logic [31:0] ERRV = 32'h8000_0000;
    localparam longint      LN2Q = 45426;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [31:0] x;
    } smp_t;

    function automatic longint ref_q16(input logic [31:0] v);
        real r;
        r = $ln(real'(v)) * 65536.0;
        return longint'(r);
    endfunction

    // Drive one input sample, then sit 1 time unit past the sampling edge.
    task automatic tick(input logic v, input logic [31:0] val);
        bus.in_valid = v;
        bus.x        = val;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1, 32'd5);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.y !== 32'h0) begin failures++; $display("FAIL reset_y: got %h want 00000000", bus.y); end
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus.err); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'd0);
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid: cycle %0d got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_single_one();
        tick(1'b1, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 32'd0);
            checks++;
            if (bus.out_valid !== (c == 3)) begin
                failures++; $display("FAIL one_latency: edge +%0d got %b want %b", c, bus.out_valid, (c == 3));
            end
        end
        checks++;
        if (bus.y !== 32'h0 || bus.err !== 1'b0) begin
            failures++; $display("FAIL one_value: got y=%h err=%b want y=00000000 err=0", bus.y, bus.err);
        end
    endtask

    task automatic test_exact_powers();
        logic [31:0] vals[$];
        longint      expv[$];
        int          n;
        vals.push_back(32'd2);    expv.push_back(LN2Q);
        vals.push_back(32'd1024); expv.push_back(10 * LN2Q);
        for (int k = 0; k <= 30; k++) begin
            vals.push_back(32'd1 << k);
            expv.push_back(longint'(k) * LN2Q);
        end
        n = vals.size();
        for (int t = 0; t < n + 3; t++) begin
            tick(t < n, (t < n) ? vals[t] : 32'd0);
            if (t >= 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.err !== 1'b0 || longint'(bus.y) != expv[t-3]) begin
                    failures++;
                    $display("FAIL exact_pow x=%0d: got v=%b err=%b y=%0d want v=1 err=0 y=%0d",
                             vals[t-3], bus.out_valid, bus.err, bus.y, expv[t-3]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 32'd0);
            checks++;
            if (bus.out_valid !== 1'b0 || longint'(bus.y) != 30 * LN2Q) begin
                failures++; $display("FAIL exact_hold: got v=%b y=%0d want v=0 y=%0d", bus.out_valid, bus.y, 30 * LN2Q);
            end
        end
    endtask

    task automatic test_x101();
        longint d;
        tick(1'b1, 32'd101);
        for (int c = 0; c < 3; c++) tick(1'b0, 32'd0);
        d = longint'(bus.y) - 64'sd302456;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.err !== 1'b0 || d < -TOL || d > TOL) begin
            failures++;
            $display("FAIL x101: got v=%b err=%b y=%0d want v=1 err=0 y=302456+-%0d", bus.out_valid, bus.err, bus.y, TOL);
        end
    endtask

    task automatic test_domain();
        logic [31:0] vals[4];
        vals = '{32'd0, 32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int t = 0; t < 7; t++) begin
            tick(t < 4, (t < 4) ? vals[t] : 32'd0);
            if (t >= 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.err !== 1'b1 || bus.y !== ERRV) begin
                    failures++;
                    $display("FAIL domain x=%h: got v=%b err=%b y=%h want v=1 err=1 y=%h",
                             vals[t-3], bus.out_valid, bus.err, bus.y, ERRV);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 32'd0);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.err !== 1'b1 || bus.y !== ERRV) begin
                failures++; $display("FAIL domain_hold: got v=%b err=%b y=%h want v=0 err=1 y=%h", bus.out_valid, bus.err, bus.y, ERRV);
            end
        end
    endtask

    task automatic test_back_to_back();
        int     seen;
        longint d;
        seen = 0;
        for (int t = 0; t < 106; t++) begin
            tick(t < 100, 32'(t + 1));
            if (t >= 3 && t < 103) begin
                if (bus.out_valid === 1'b1) seen++;
                d = longint'(bus.y) - ref_q16(32'(t - 2));
                checks++;
                if (bus.out_valid !== 1'b1 || bus.err !== 1'b0 || d < -TOL || d > TOL) begin
                    failures++;
                    $display("FAIL b2b n=%0d: got v=%b err=%b y=%0d want v=1 err=0 y=%0d+-%0d",
                             t - 2, bus.out_valid, bus.err, bus.y, ref_q16(32'(t - 2)), TOL);
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    failures++; $display("FAIL b2b_idle: cycle %0d got v=%b want 0", t, bus.out_valid);
                end
            end
        end
        checks++;
        if (seen != 100) begin failures++; $display("FAIL b2b_count: got %0d want 100", seen); end
    endtask

    task automatic test_random();
        smp_t        pipe[$];
        smp_t        cur;
        logic        v;
        logic [31:0] xv;
        logic        last_err;
        longint      d;
        last_err = 1'b0;
        for (int t = 0; t < 303; t++) begin
            v  = (t < 300) && ($urandom_range(3) != 0);
            case ($urandom_range(4))
                0: xv = $urandom;
                1: xv = 32'($urandom_range(1, 1000));
                2: xv = 32'd1 << $urandom_range(0, 30);
                3: xv = 32'(-int'($urandom_range(0, 10)));
                default: xv = 32'($urandom_range(1, 65535));
            endcase
            tick(v, xv);
            pipe.push_back('{v, xv});
            if (pipe.size() > 3) begin
                cur = pipe.pop_front();
                checks++;
                if (bus.out_valid !== cur.v) begin
                    failures++; $display("FAIL rand_valid: cycle %0d got %b want %b", t, bus.out_valid, cur.v);
                end else if (cur.v && $signed(cur.x) <= 0) begin
                    last_err = 1'b1;
                    if (bus.err !== 1'b1 || bus.y !== ERRV) begin
                        failures++; $display("FAIL rand_err x=%h: got err=%b y=%h want err=1 y=%h", cur.x, bus.err, bus.y, ERRV);
                    end
                end else if (cur.v) begin
                    last_err = 1'b0;
                    d = longint'(bus.y) - ref_q16(cur.x);
                    if (bus.err !== 1'b0 || d < -TOL || d > TOL) begin
                        failures++;
                        $display("FAIL rand_y x=%0d: got err=%b y=%0d want err=0 y=%0d+-%0d", cur.x, bus.err, bus.y, ref_q16(cur.x), TOL);
                    end
                end else if (bus.err !== last_err) begin
                    failures++; $display("FAIL rand_err_hold: got err=%b want %b", bus.err, last_err);
                end
            end
        end
    endtask

    task automatic test_reset_flush();
        tick(1'b1, 32'd7);
        tick(1'b1, 32'd9);
        rst_n = 1'b0;
        tick(1'b0, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'd0);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.y !== 32'h0 || bus.err !== 1'b0) begin
                failures++; $display("FAIL flush: cycle %0d got v=%b y=%h err=%b want v=0 y=00000000 err=0", i, bus.out_valid, bus.y, bus.err);
            end
        end
        tick(1'b1, 32'd4);
        for (int c = 1; c <= 3; c++) begin
            tick(1'b0, 32'd0);
            checks++;
            if (bus.out_valid !== (c == 3)) begin
                failures++; $display("FAIL post_reset_latency: edge +%0d got %b want %b", c, bus.out_valid, (c == 3));
            end
        end
        checks++;
        if (longint'(bus.y) != 2 * LN2Q || bus.err !== 1'b0) begin
            failures++; $display("FAIL post_reset_y: got y=%0d err=%b want y=%0d err=0", bus.y, bus.err, 2 * LN2Q);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        test_reset();
        test_single_one();
        test_exact_powers();
        test_x101();
        test_domain();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
